// File: rtl/rv_pkg.sv
// Shared writeback types: register index/data widths and the buffered result entry.
package rv_pkg;

    localparam int unsigned DATA_WIDTH  = 32;
    localparam int unsigned REG_NUM     = 32;
    localparam int unsigned REG_NUM_BIT = 5;

    typedef struct packed {
        logic [REG_NUM_BIT-1:0] rd;
        logic [DATA_WIDTH-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_stage_if.sv
// Writeback stage bus: issue handshake, ALU/LSU result channels, RF write port and hazard checks.
interface wb_stage_if;
    import rv_pkg::*;

    logic                   issue_valid;
    logic [REG_NUM_BIT-1:0] issue_rd;
    logic                   issue_ready;

    logic                   alu_valid;
    logic [REG_NUM_BIT-1:0] alu_rd;
    logic [DATA_WIDTH-1:0]  alu_data;
    logic                   alu_ready;

    logic                   lsu_valid;
    logic [REG_NUM_BIT-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0]  lsu_data;
    logic                   lsu_ready;

    logic                   rf_wen;
    logic [REG_NUM_BIT-1:0] rf_waddr;
    logic [DATA_WIDTH-1:0]  rf_wdata;

    logic [REG_NUM_BIT-1:0] chk_rs1;
    logic [REG_NUM_BIT-1:0] chk_rs2;
    logic                   rs1_busy;
    logic                   rs2_busy;

    modport master (
        output issue_valid, issue_rd,
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output chk_rs1, chk_rs2,
        input  issue_ready, alu_ready, lsu_ready,
        input  rf_wen, rf_waddr, rf_wdata,
        input  rs1_busy, rs2_busy
    );

    modport slave (
        input  issue_valid, issue_rd,
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  chk_rs1, chk_rs2,
        output issue_ready, alu_ready, lsu_ready,
        output rf_wen, rf_waddr, rf_wdata,
        output rs1_busy, rs2_busy
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU/LSU results into a FIFO, drains one RF write per cycle,
// and tracks per-register outstanding writes for RAW hazard checks.
module wb_stage
    import rv_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned PEND_W     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    wb_stage_if.slave  bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t              w_push_entry;
    wb_entry_t              w_head;
    logic                   w_lsu_fire;
    logic                   w_alu_fire;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [CW-1:0]          w_count;
    logic                   w_issue_fire;
    logic [REG_NUM-1:0]     w_inc;
    logic [REG_NUM-1:0]     w_dec;

    logic                   r_rf_wen;
    logic [REG_NUM_BIT-1:0] r_rf_waddr;
    logic [DATA_WIDTH-1:0]  r_rf_wdata;
    logic [PEND_W-1:0]      r_pend [REG_NUM];

    // LSU has strict priority; ALU is only offered the slot when no load is waiting.
    assign bus.lsu_ready = !w_full;
    assign bus.alu_ready = !w_full && !bus.lsu_valid;
    assign w_lsu_fire    = bus.lsu_valid && bus.lsu_ready;
    assign w_alu_fire    = bus.alu_valid && bus.alu_ready;
    assign w_pop         = !w_empty;

    always_comb begin
        w_push       = 1'b0;
        w_push_entry = '{rd: bus.alu_rd, data: bus.alu_data};
        if (w_lsu_fire) begin
            w_push_entry = '{rd: bus.lsu_rd, data: bus.lsu_data};
            w_push       = (bus.lsu_rd != '0);
        end else if (w_alu_fire) begin
            w_push       = (bus.alu_rd != '0);
        end
    end

    sync_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_push_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rf_wen   <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_wen <= w_pop;
            if (w_pop) begin
                r_rf_waddr <= w_head.rd;
                r_rf_wdata <= w_head.data;
            end
        end
    end

    assign bus.rf_wen   = r_rf_wen;
    assign bus.rf_waddr = r_rf_waddr;
    assign bus.rf_wdata = r_rf_wdata;

    // A write retiring this cycle frees a slot, so a saturated register may still issue.
    assign bus.issue_ready = (bus.issue_rd == '0) || (r_pend[bus.issue_rd] != '1)
                           || w_dec[bus.issue_rd];
    assign w_issue_fire    = bus.issue_valid && bus.issue_ready && (bus.issue_rd != '0);

    always_comb begin
        w_inc = '0;
        w_dec = '0;
        if (w_issue_fire) begin
            w_inc[bus.issue_rd] = 1'b1;
        end
        if (r_rf_wen) begin
            w_dec[r_rf_waddr] = 1'b1;
        end
    end

    // x0 is never incremented (issue filter) nor decremented (never enqueued), so it stays 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                r_pend[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < REG_NUM; r++) begin
                if (w_inc[r] && !w_dec[r]) begin
                    r_pend[r] <= r_pend[r] + PEND_W'(1);
                end else if (w_dec[r] && !w_inc[r] && (r_pend[r] != '0)) begin
                    r_pend[r] <= r_pend[r] - PEND_W'(1);
                end
            end
        end
    end

    assign bus.rs1_busy = (r_pend[bus.chk_rs1] != '0);
    assign bus.rs2_busy = (r_pend[bus.chk_rs2] != '0);

    a_no_unissued_write: assert property (@(posedge clk) disable iff (!rst_n)
        r_rf_wen |-> (r_pend[r_rf_waddr] != '0));
    a_count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        w_count <= CW'(FIFO_DEPTH));

endmodule
